// File: rtl/hex_string_serializer.sv
// Serializes a binary word into an ASCII hex string, one character per beat.
// Define HEX_SER_NEWLINE_EN to append CR LF after the last digit.
module hex_string_serializer #(
  parameter int DATA_W     = 32,
  parameter bit UPPER_CASE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_prefix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int NDIG = DATA_W / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] ALPHA = UPPER_CASE ? 8'h41 : 8'h61;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  typedef enum logic [2:0] {
    IDLE,
    PFX0,
    PFX1,
    DIGITS
`ifdef HEX_SER_NEWLINE_EN
    ,
    CR,
    LF
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [3:0]        nib;
  logic [7:0]        dig_char;
  logic              last_dig;
  logic              in_xfer;
  logic              out_xfer;

  assign in_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_dig = (cnt_q == LAST_IDX);

  // Word is shifted left per digit, so the current nibble is always on top
  assign nib      = word_q[DATA_W-1 -: 4];
  assign dig_char = (nib <= 4'd9) ? (8'h30 + {4'h0, nib})
                                  : (ALPHA + {4'h0, nib} - 8'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          word_d  = in_data;
          cnt_d   = '0;
          state_d = in_prefix ? PFX0 : DIGITS;
        end
      end
      PFX0: begin
        out_valid = 1'b1;
        out_char  = 8'h30;
        if (out_xfer) state_d = PFX1;
      end
      PFX1: begin
        out_valid = 1'b1;
        out_char  = 8'h78;
        if (out_xfer) state_d = DIGITS;
      end
      DIGITS: begin
        out_valid = 1'b1;
        out_char  = dig_char;
`ifndef HEX_SER_NEWLINE_EN
        out_last  = last_dig;
`endif
        if (out_xfer) begin
          word_d = word_q << 4;
          if (last_dig) begin
            cnt_d = '0;
`ifdef HEX_SER_NEWLINE_EN
            state_d = CR;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef HEX_SER_NEWLINE_EN
      CR: begin
        out_valid = 1'b1;
        out_char  = 8'h0D;
        if (out_xfer) state_d = LF;
      end
      LF: begin
        out_valid = 1'b1;
        out_char  = 8'h0A;
        out_last  = 1'b1;
        if (out_xfer) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_string_serializer.sv
// Bench for hex_string_serializer: three widths (8, 32 upper, 16),
// vector table, stall/reset sequences and random strings vs a string model.
module tb_hex_string_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       iv, pfx, ord, ir, ov, ol, bz;
  logic [2:0][31:0] din;
  logic [2:0][7:0]  oc;

  hex_string_serializer #(.DATA_W(8), .UPPER_CASE(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din[0][7:0]), .in_prefix(pfx[0]),
    .out_valid(ov[0]), .out_ready(ord[0]),
    .out_char(oc[0]), .out_last(ol[0]), .busy(bz[0])
  );

  hex_string_serializer #(.DATA_W(32), .UPPER_CASE(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[1]), .in_prefix(pfx[1]),
    .out_valid(ov[1]), .out_ready(ord[1]),
    .out_char(oc[1]), .out_last(ol[1]), .busy(bz[1])
  );

  hex_string_serializer #(.DATA_W(16), .UPPER_CASE(1'b0)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[2][15:0]), .in_prefix(pfx[2]),
    .out_valid(ov[2]), .out_ready(ord[2]),
    .out_char(oc[2]), .out_last(ol[2]), .busy(bz[2])
  );

  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic string nl();
`ifdef HEX_SER_NEWLINE_EN
    return "\r\n";
`else
    return "";
`endif
  endfunction

  // Reference: printf-style rendering, trimmed to the instance width
  function automatic string model(int k, logic [31:0] d, bit p);
    int w;
    string h;
    w = (k == 0) ? 8 : (k == 1) ? 32 : 16;
    h = $sformatf("%08h", d);
    h = h.substr(8 - w / 4, 7);
    if (k == 1) h = h.toupper();
    if (p) h = {"0x", h};
    return {h, nl()};
  endfunction

  task automatic cmp(string nm, string got, string exp);
    chk({nm, "_len"}, got.len(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      chk({nm, "_char"}, (i < got.len()) ? got[i] : 8'h00, exp[i]);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on 3rd char
  task automatic run(input int k, input logic [31:0] d, input bit p,
                     input int mode, input bit hold_iv, input int len,
                     output string got, output int cyc);
    logic [7:0] pc;
    logic pl, pv, pr;
    int n, stall;
    bit done;
    got = ""; cyc = 0; stall = 0; n = 0; done = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", ir[k], 1);
    iv[k] = 1'b1; din[k] = d; pfx[k] = p;
    @(negedge clk);
    if (hold_iv) begin
      din[k] = ~d;
      pfx[k] = ~p;
    end else begin
      iv[k] = 1'b0;
    end
    chk("first_valid", ov[k], 1);
    pv = 0; pr = 0; pc = 0; pl = 0; n = 0;
    while (!done && n < 300) begin
      if (pv && !pr) begin
        chk("hold_valid", ov[k], 1);
        chk("hold_char", oc[k], pc);
        chk("hold_last", ol[k], pl);
      end
      chk("busy", bz[k], 1);
      chk("ready_busy", ir[k], 0);
      case (mode)
        0: ord[k] = 1'b1;
        1: ord[k] = 1'($urandom_range(0, 1));
        default: begin
          if (got.len() == 2 && stall < 3) begin
            ord[k] = 1'b0;
            stall++;
            chk("stall_char", oc[k], 8'h66);
          end else begin
            ord[k] = 1'b1;
          end
        end
      endcase
      if (ov[k] && ord[k]) begin
        got = {got, $sformatf("%c", oc[k])};
        chk("last_flag", ol[k], got.len() == len);
        done = ol[k] || (got.len() >= len);
        if (done) iv[k] = 1'b0;
      end
      pv = ov[k]; pr = ord[k]; pc = oc[k]; pl = ol[k];
      cyc++; n++;
      @(negedge clk);
    end
    if (!done) chk("timeout", 0, 1);
    chk("ready_after", ir[k], 1);
    chk("idle_valid", ov[k], 0);
    chk("idle_char", oc[k], 0);
    chk("idle_busy", bz[k], 0);
    ord[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [31:0] d;
    bit          p;
    string       exp;
  } vec_t;

  initial begin
    vec_t tbl[8];
    string got, exp;
    int cyc, k;
    logic [31:0] d;
    bit p, h;

    tbl[0] = '{0, 32'h0000003A, 1'b1, "0x3a"};
    tbl[1] = '{1, 32'hDEADBEEF, 1'b0, "DEADBEEF"};
    tbl[2] = '{2, 32'h000000F0, 1'b0, "00f0"};
    tbl[3] = '{0, 32'h00000000, 1'b0, "00"};
    tbl[4] = '{0, 32'h000000FF, 1'b1, "0xff"};
    tbl[5] = '{2, 32'h0000A5C3, 1'b1, "0xa5c3"};
    tbl[6] = '{1, 32'h00000000, 1'b1, "0x00000000"};
    tbl[7] = '{1, 32'h1234ABCD, 1'b0, "1234ABCD"};

    rst = 1'b1; iv = '0; pfx = '0; ord = '0; din = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", ir[i], 0);
      chk("rst_valid", ov[i], 0);
      chk("rst_char", oc[i], 0);
      chk("rst_last", ol[i], 0);
      chk("rst_busy", bz[i], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_post_rst", ir[i], 1);

    for (int i = 0; i < 8; i++) begin
      exp = {tbl[i].exp, nl()};
      run(tbl[i].k, tbl[i].d, tbl[i].p, 0, (i == 1), exp.len(), got, cyc);
      cmp("vec", got, exp);
      chk("vec_cycles", cyc, exp.len());
    end

    exp = {"00f0", nl()};
    run(2, 32'h00F0, 1'b0, 2, 1'b0, exp.len(), got, cyc);
    cmp("stall", got, exp);

    // Asynchronous reset while the second digit is on the output
    iv[1] = 1'b1; din[1] = 32'hDEADBEEF; pfx[1] = 1'b0;
    @(negedge clk);
    iv[1] = 1'b0; ord[1] = 1'b1;
    chk("pre_rst_char0", oc[1], 8'h44);
    @(negedge clk);
    chk("pre_rst_char1", oc[1], 8'h45);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[1], 0);
    chk("mid_rst_char", oc[1], 0);
    chk("mid_rst_busy", bz[1], 0);
    chk("mid_rst_ready", ir[1], 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ready", ir[1], 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", ov[1], 0);
    end
    ord[1] = 1'b0;

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 2);
      d = $urandom;
      p = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      exp = model(k, d, p);
      run(k, d, p, 1, h, exp.len(), got, cyc);
      cmp("rand", got, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_string_serializer.md
HEX_STRING_SERIALIZER -- requirements
Module: hex_string_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: input word width; SHALL be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter UPPER_CASE, default 0: 0 = hex letters 'a'-'f', 1 = 'A'-'F'.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: word on in_data is offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept a word.
REQ-007 SHALL have port in_data, input, DATA_W: binary word to render.
REQ-008 SHALL have port in_prefix, input, 1: emit "0x" before the digits.
REQ-009 SHALL have port out_valid, output, 1: out_char holds a valid character.
REQ-010 SHALL have port out_ready, input, 1: sink accepts out_char.
REQ-011 SHALL have port out_char, output, 8: ASCII character.
REQ-012 SHALL have port out_last, output, 1: out_char is the final character of the string.
REQ-013 SHALL have port busy, output, 1: string in progress (state not IDLE).

Function
REQ-014 Input transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; in_data and in_prefix SHALL be captured into internal registers at that edge.
REQ-015 in_ready SHALL be 1 only in state IDLE; in_valid while busy SHALL be ignored with no side effects.
REQ-016 Output transfer SHALL occur on a rising clk edge with out_valid=1 and out_ready=1.
REQ-017 Latency: out_valid SHALL assert with the first character in the cycle immediately after input transfer.
REQ-018 While out_valid=1 and out_ready=0, out_char and out_last SHALL hold stable; out_valid SHALL not deassert before transfer.
REQ-019 States: IDLE, PFX0 ('0', 0x30), PFX1 ('x', 0x78, lowercase regardless of UPPER_CASE), DIGITS, plus CR and LF when configured (REQ-029).
REQ-020 Transitions: IDLE->PFX0 on transfer with in_prefix=1, else IDLE->DIGITS; PFX0->PFX1->DIGITS on each output transfer.
REQ-021 DIGITS SHALL emit DATA_W/4 characters, most-significant nibble first, using a digit counter of width $clog2(DATA_W/4) (minimum 1 bit).
REQ-022 Nibble n SHALL map to "0"+n for n<=9, else "a"+(n-10) (or "A"+(n-10) if UPPER_CASE=1); arithmetic SHALL be 8-bit, no wrap.
REQ-023 out_last SHALL be 1 only on the final character of the string; after its transfer the state SHALL return to IDLE and in_ready SHALL be 1 the next cycle (no same-cycle re-accept).
REQ-024 out_valid SHALL be 0 in IDLE; out_char SHALL read 0x00 whenever out_valid=0.
REQ-025 Leading zeros SHALL be emitted (fixed-width string).

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, digit counter 0, captured word 0, out_valid=0, out_last=0, out_char=0x00, busy=0, in_ready=0 while rst=1.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 Reset mid-string SHALL abort the string with no further characters emitted.

Configuration
REQ-029 Macro HEX_SER_NEWLINE_EN defined: after the last digit SHALL emit CR (0x0D) then LF (0x0A); out_last SHALL mark LF only.
REQ-030 Macro HEX_SER_NEWLINE_EN undefined: CR/LF states SHALL not exist; out_last SHALL mark the last digit.

Verification
REQ-031 DATA_W=8, in_data=0x3A, in_prefix=1, out_ready=1 -> chars 0x30,0x78,0x33,0x61 on 4 consecutive cycles; out_last on 0x61 only; in_ready=1 next cycle.
REQ-032 DATA_W=32, in_data=0xDEADBEEF, in_prefix=0, UPPER_CASE=1 -> "DEADBEEF" (8 chars), out_last on 8th; second in_valid during string ignored.
REQ-033 DATA_W=16, in_data=0x00F0, out_ready low 3 cycles on 3rd char -> 'f' (0x66) held stable 3 cycles, then "0","0","f","0" complete without loss or duplication.
REQ-034 rst pulsed asynchronously (mid-cycle) during 2nd digit -> out_valid=0 immediately, no further chars; in_ready=1 the cycle after release.
REQ-035 HEX_SER_NEWLINE_EN defined, DATA_W=8, in_data=0x09, in_prefix=0 -> chars 0x30,0x39,0x0D,0x0A; out_last on 0x0A only.
